// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-SRAM arbiter: FSM encoding, wait-cycle
// limits and the access counter width.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACC_D = 2'd1,
      ACC_I = 2'd2
   } arbState_e;

   localparam int WAIT_MIN = 1;
   localparam int WAIT_MAX = 7;
   localparam int CNT_W    = 3;

   // Keeps an out-of-range WAIT_CYCLES from loading a zero or wrapped count.
   function automatic logic [CNT_W-1:0] waitLoad(input int cycles);
      if (cycles < WAIT_MIN) return CNT_W'(WAIT_MIN);
      if (cycles > WAIT_MAX) return CNT_W'(WAIT_MAX);
      return CNT_W'(cycles);
   endfunction

endpackage

// File: rtl/mem_arb_ibuf.sv
// One-entry instruction buffer (valid, tag address, word); only elaborated
// when MEM_ARB_IBUF_EN is defined.
`ifdef MEM_ARB_IBUF_EN
module mem_arb_ibuf (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_fill,
   input  logic [31:0] i_fillAddr,
   input  logic [31:0] i_fillData,
   input  logic        i_inval,
   input  logic [31:0] i_invalAddr,
   input  logic [31:0] i_lookupAddr,
   output logic        o_hit,
   output logic [31:0] o_word
);

   logic        r_valid;
   logic [31:0] r_tag;
   logic [31:0] r_word;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_tag   <= '0;
         r_word  <= '0;
      end else if (i_fill) begin
         r_valid <= 1'b1;
         r_tag   <= i_fillAddr;
         r_word  <= i_fillData;
      end else if (i_inval && r_valid && (r_tag == i_invalAddr)) begin
         r_valid <= 1'b0;
      end
   end

   assign o_hit  = r_valid && (r_tag == i_lookupAddr);
   assign o_word = r_word;

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port SRAM between instruction fetch and data access,
// data first. Optional instruction buffer enabled by MEM_ARB_IBUF_EN.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_ce_i,
   input  logic [31:0] if_addr_i,
   output logic [31:0] if_data_o,
   input  logic        d_ce_i,
   input  logic        d_we_i,
   input  logic [31:0] d_addr_i,
   input  logic [31:0] d_data_i,
   output logic [31:0] d_data_o,
   output logic        sram_ce_o,
   output logic        sram_we_o,
   output logic [31:0] sram_addr_o,
   output logic [31:0] sram_wdata_o,
   input  logic [31:0] sram_rdata_i,
   output logic        stallreq_o
);

   localparam logic [CNT_W-1:0] W_LOAD = waitLoad(WAIT_CYCLES);

   arbState_e        r_state;
   arbState_e        w_nextState;
   logic [CNT_W-1:0] r_waitCnt;
   logic             r_doneD;
   logic             r_doneI;
   logic             r_sramCe;
   logic             r_sramWe;
   logic [31:0]      r_sramAddr;
   logic [31:0]      r_sramWdata;
   logic [31:0]      r_ifData;
   logic [31:0]      r_dData;
   logic             w_dPend;
   logic             w_iPend;
   logic             w_lastAcc;
   logic             w_ibufHit;
   logic [31:0]      w_ibufWord;

   assign w_dPend    = d_ce_i & ~r_doneD;
   assign w_iPend    = if_ce_i & ~r_doneI;
   assign stallreq_o = w_dPend | w_iPend;
   assign w_lastAcc  = (r_state != IDLE) && (r_waitCnt == CNT_W'(1));

`ifdef MEM_ARB_IBUF_EN
   mem_arb_ibuf u_ibuf (
      .clk          (clk),
      .rst          (rst),
      .i_fill       ((r_state == ACC_I) && w_lastAcc),
      .i_fillAddr   (r_sramAddr),
      .i_fillData   (sram_rdata_i),
      .i_inval      ((r_state == IDLE) && w_dPend && d_we_i),
      .i_invalAddr  (d_addr_i),
      .i_lookupAddr (if_addr_i),
      .o_hit        (w_ibufHit),
      .o_word       (w_ibufWord)
   );
`else
   assign w_ibufHit  = 1'b0;
   assign w_ibufWord = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_dPend)                    w_nextState = ACC_D;
            else if (w_iPend && !w_ibufHit) w_nextState = ACC_I;
         end
         ACC_D, ACC_I: begin
            if (w_lastAcc) w_nextState = IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Done flags clear once the pipeline stops stalling; a completion in the
   // same cycle wins so a request dropped mid-access still gets its flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_waitCnt   <= '0;
         r_doneD     <= 1'b0;
         r_doneI     <= 1'b0;
         r_sramCe    <= 1'b0;
         r_sramWe    <= 1'b0;
         r_sramAddr  <= '0;
         r_sramWdata <= '0;
         r_ifData    <= '0;
         r_dData     <= '0;
      end else begin
         if (!stallreq_o) begin
            r_doneD <= 1'b0;
            r_doneI <= 1'b0;
         end
         case (r_state)
            IDLE: begin
               if (w_dPend) begin
                  r_sramCe    <= 1'b1;
                  r_sramWe    <= d_we_i;
                  r_sramAddr  <= d_addr_i;
                  r_sramWdata <= d_data_i;
                  r_waitCnt   <= W_LOAD;
               end else if (w_iPend) begin
                  if (w_ibufHit) begin
                     r_ifData <= w_ibufWord;
                     r_doneI  <= 1'b1;
                  end else begin
                     r_sramCe   <= 1'b1;
                     r_sramWe   <= 1'b0;
                     r_sramAddr <= if_addr_i;
                     r_waitCnt  <= W_LOAD;
                  end
               end
            end
            ACC_D, ACC_I: begin
               if (w_lastAcc) begin
                  r_sramCe  <= 1'b0;
                  r_sramWe  <= 1'b0;
                  r_waitCnt <= '0;
                  if (r_state == ACC_D) begin
                     if (!r_sramWe) r_dData <= sram_rdata_i;
                     r_doneD <= 1'b1;
                  end else begin
                     r_ifData <= sram_rdata_i;
                     r_doneI  <= 1'b1;
                  end
               end else begin
                  r_waitCnt <= r_waitCnt - CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign sram_ce_o    = r_sramCe;
   assign sram_we_o    = r_sramWe;
   assign sram_addr_o  = r_sramAddr;
   assign sram_wdata_o = r_sramWdata;
   assign if_data_o    = r_ifData;
   assign d_data_o     = r_dData;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1; SRAM cycles per access, legal range 1..7.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have ports if_ce_i in 1, if_addr_i in 32, if_data_o out 32: instruction-fetch request, address and returned word.
REQ-005 SHALL have ports d_ce_i in 1, d_we_i in 1, d_addr_i in 32, d_data_i in 32, d_data_o out 32: data request, write flag, address, write data, read data.
REQ-006 SHALL have ports sram_ce_o out 1, sram_we_o out 1, sram_addr_o out 32, sram_wdata_o out 32, sram_rdata_i in 32: single-port unified SRAM.
REQ-007 SHALL have port stallreq_o  out  1  stall request to the pipeline stall controller.

Function
REQ-008 SHALL share one SRAM between fetch and data ports; the pipeline holds each request stable while stallreq_o=1.
REQ-009 SHALL implement FSM states IDLE, ACC_D, ACC_I.
REQ-010 In IDLE: pending data (d_ce_i & ~done_d) -> latch d_addr/d_we/d_data, go ACC_D; else pending fetch (if_ce_i & ~done_i) -> latch if_addr, go ACC_I; else stay.
REQ-011 Data SHALL have fixed priority over fetch when both are pending in IDLE.
REQ-012 SHALL drive sram_ce_o=1 and the latched address/write data from registers for exactly WAIT_CYCLES cycles in ACC_*; sram_we_o=1 only in ACC_D with latched we=1.
REQ-013 On the last ACC cycle, SHALL register sram_rdata_i into d_data_o (ACC_D read) or if_data_o (ACC_I), set done_d/done_i, return to IDLE.
REQ-014 A data write SHALL set done_d and leave d_data_o unchanged.
REQ-015 stallreq_o SHALL equal (d_ce_i & ~done_d) | (if_ce_i & ~done_i), combinational from inputs and registers.
REQ-016 done_d and done_i SHALL clear at every edge where stallreq_o=0 (requests consumed).
REQ-017 Single request latency SHALL be WAIT_CYCLES+1 stall cycles; simultaneous data+fetch SHALL be 2*(WAIT_CYCLES+1).
REQ-018 An internal wait counter SHALL be 3 bits, loaded on ACC entry, never wrapping.
REQ-019 A request deasserted mid-access SHALL still complete its SRAM cycle; its done flag clears on the next stallreq_o=0 edge.
REQ-020 Out of reset with no requests: stallreq_o=0, sram_ce_o=0.

Reset
REQ-021 rst SHALL force, at the next edge: state IDLE, counter 0, done_d=done_i=0, if_data_o=d_data_o=0, sram_ce_o=sram_we_o=0, sram_addr_o=sram_wdata_o=0.
REQ-022 rst during ACC_* SHALL abort the access with no write-back and no done flag.

Configuration
REQ-023 Macro MEM_ARB_IBUF_EN SHALL enable a one-entry instruction buffer (valid, tag addr, word).
REQ-024 With MEM_ARB_IBUF_EN: an ACC_I completion fills the buffer; a fetch whose if_addr_i equals a valid tag sets done_i and loads if_data_o in IDLE without an SRAM access (1 stall cycle); any data write to the tagged address invalidates the entry; rst clears valid.
REQ-025 Without MEM_ARB_IBUF_EN: every fetch accesses SRAM; no buffer storage exists.

Structure
REQ-026 FSM state encoding, WAIT_CYCLES limits and counter width SHALL live in the shared package.
REQ-027 The buffer SHALL be sub-module mem_arb_ibuf, instantiated only under MEM_ARB_IBUF_EN.

Verification
REQ-028 W=1, fetch 0x00000010 alone, SRAM returns 0x24010005 -> stallreq_o high 2 cycles, if_data_o=0x24010005, one SRAM read.
REQ-029 W=1, simultaneous data read 0x100 (0xDEADBEEF) and fetch 0x14 -> data access first, then fetch; stallreq_o high 4 cycles; both outputs correct.
REQ-030 W=3, data write 0x200 <- 0x12345678 -> sram_we_o high 3 cycles with correct addr/data; stallreq_o high 4 cycles; d_data_o unchanged.
REQ-031 rst asserted in 2nd cycle of W=3 ACC_D write -> sram_ce_o/sram_we_o 0 next cycle, done_d=0, outputs zero.
REQ-032 MEM_ARB_IBUF_EN, fetch 0x20 twice -> second fetch: no sram_ce_o, 1 stall cycle; after data write to 0x20, next fetch 0x20 accesses SRAM.
REQ-033 No requests for 10 cycles after reset -> stallreq_o=0, sram_ce_o=0 throughout.
